// File: rtl/xor_accum_unit_if.sv
// Handshake/data bundle for xor_accum_unit.
//   master : upstream/downstream side (drives operands, in_valid, in_last, mode, out_ready)
//   slave  : the xor_accum_unit itself (drives in_ready, out_valid, f, f_parity, beat_cnt)
// Signals:
//   mode      0 = pairwise XOR per beat, 1 = XOR-accumulate over a frame
//   in_valid  input beat offered          in_ready   unit can accept a beat
//   a, b      operands (WIDTH)            in_last    last beat of a mode-1 frame
//   out_valid result held                 out_ready  downstream accepts result
//   f         result (WIDTH)              f_parity   XOR-reduction of f
//   beat_cnt  beats that formed f (CNT_W, saturating)
interface xor_accum_unit_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
);
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic             f_parity;
  logic [CNT_W-1:0] beat_cnt;

  modport master (
    output mode, in_valid, a, b, in_last, out_ready,
    input  in_ready, out_valid, f, f_parity, beat_cnt
  );

  modport slave (
    input  mode, in_valid, a, b, in_last, out_ready,
    output in_ready, out_valid, f, f_parity, beat_cnt
  );
endinterface

// File: rtl/xor_accum_unit.sv
// XOR / XOR-accumulate unit with valid/ready handshake on both sides.
// Mode 0 returns a^b for every accepted beat one cycle later. Mode 1 folds
// a^b of every beat of a frame into an accumulator and returns the XOR of
// the whole frame, with a saturating beat count, after the in_last beat.
// A single output register holds the result; in_ready = !out_valid || out_ready
// so a new result can replace one leaving in the same cycle without a bubble.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-low reset
//   bus  xor_accum_unit_if.slave (handshake, operands, result)
module xor_accum_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  xor_accum_unit_if.slave bus
);

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  state_t           state;
  logic             mode_q;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic             out_valid_q;
  logic [WIDTH-1:0] f_q;
  logic             par_q;
  logic [CNT_W-1:0] bcnt_q;

  logic             in_ready;
  logic             accept;
  logic             emit;
  logic [WIDTH-1:0] beat_x;
  logic [WIDTH-1:0] sum;
  logic [CNT_W-1:0] cnt_sat;
  logic [CNT_W-1:0] end_cnt;

  always_comb begin
    in_ready = !out_valid_q || bus.out_ready;
    accept   = bus.in_valid && in_ready;
    beat_x   = bus.a ^ bus.b;
    cnt_sat  = (cnt == '1) ? cnt : cnt + 1'b1;
    emit     = 1'b0;
    sum      = beat_x;
    end_cnt  = CNT_W'(1);
    case (state)
      IDLE: begin
        // Mode is sampled live here; it is latched into mode_q on accept.
        emit    = !bus.mode || bus.in_last;
        sum     = beat_x;
        end_cnt = CNT_W'(1);
      end
      ACCUM: begin
        // Only a mode-1 frame can reach ACCUM, so the live mode input is
        // ignored and the latched mode decides.
        emit    = bus.in_last || !mode_q;
        sum     = acc ^ beat_x;
        end_cnt = cnt_sat;
      end
      default: begin
        emit    = 1'b0;
        sum     = beat_x;
        end_cnt = CNT_W'(1);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      mode_q      <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      f_q         <= '0;
      par_q       <= 1'b0;
      bcnt_q      <= '0;
    end else begin
      // Drop the held result when it leaves; a beat that emits in the same
      // cycle overrides this below, giving back-to-back results.
      if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept) begin
        if (state == IDLE) begin
          mode_q <= bus.mode;
        end
        if (emit) begin
          f_q         <= sum;
          par_q       <= ^sum;
          bcnt_q      <= end_cnt;
          out_valid_q <= 1'b1;
          acc         <= '0;
          cnt         <= '0;
          state       <= IDLE;
        end else begin
          acc   <= sum;
          cnt   <= end_cnt;
          state <= ACCUM;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.f         = f_q;
  assign bus.f_parity  = par_q;
  assign bus.beat_cnt  = bcnt_q;

endmodule

// File: tb/tb_xor_accum_unit.sv
// Bench for xor_accum_unit: directed vectors plus randomized traffic checked
// against a frame-level reference model (list of beat XORs per frame).
// Two instances share stimulus: CNT_W=8 and CNT_W=2 (saturation).
module tb_xor_accum_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xor_accum_unit_if #(.WIDTH(8), .CNT_W(8)) bus   ();
  xor_accum_unit_if #(.WIDTH(8), .CNT_W(2)) bus_s ();

  xor_accum_unit #(.WIDTH(8), .CNT_W(8)) dut     (.clk(clk), .rst(rst), .bus(bus));
  xor_accum_unit #(.WIDTH(8), .CNT_W(2)) dut_sat (.clk(clk), .rst(rst), .bus(bus_s));

  int unsigned n_checks;
  int unsigned n_fail;

  // Reference model: frame contents as a queue of per-beat XORs.
  logic [7:0] m_beats[$];
  bit         m_inframe;
  bit         m_ov;
  logic [7:0] m_f;
  int unsigned m_n;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic drive(input bit md, input bit iv, input logic [7:0] aa, input logic [7:0] bb,
                       input bit lst, input bit ordy);
    bus.mode = md;    bus.in_valid = iv;   bus.a = aa;   bus.b = bb;
    bus.in_last = lst;   bus.out_ready = ordy;
    bus_s.mode = md;  bus_s.in_valid = iv; bus_s.a = aa; bus_s.b = bb;
    bus_s.in_last = lst; bus_s.out_ready = ordy;
  endtask

  task automatic model_reset();
    m_beats.delete();
    m_inframe = 1'b0;
    m_ov      = 1'b0;
    m_f       = '0;
    m_n       = 0;
  endtask

  // Evaluate one rising edge with the inputs currently driven.
  task automatic model_edge();
    bit rdy;
    bit take;
    bit ends;
    rdy  = !m_ov || bus.out_ready;
    take = bus.in_valid && rdy;
    if (m_ov && bus.out_ready) m_ov = 1'b0;
    if (take) begin
      m_beats.push_back(bus.a ^ bus.b);
      ends = (!m_inframe && !bus.mode) || bus.in_last;
      if (ends) begin
        m_f = '0;
        foreach (m_beats[i]) m_f = m_f ^ m_beats[i];
        m_n = m_beats.size();
        m_beats.delete();
        m_ov      = 1'b1;
        m_inframe = 1'b0;
      end else begin
        m_inframe = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    int unsigned e8;
    int unsigned e2;
    logic        epar;
    e8   = (m_n > 255) ? 255 : m_n;
    e2   = (m_n > 3) ? 3 : m_n;
    epar = logic'($countones(m_f) % 2);
    check_eq("in_ready", 32'(bus.in_ready), 32'(!m_ov || bus.out_ready));
    check_eq("in_ready_sat", 32'(bus_s.in_ready), 32'(!m_ov || bus_s.out_ready));
    check_eq("out_valid", 32'(bus.out_valid), 32'(m_ov));
    check_eq("out_valid_sat", 32'(bus_s.out_valid), 32'(m_ov));
    if (m_ov) begin
      check_eq("f", 32'(bus.f), 32'(m_f));
      check_eq("f_parity", 32'(bus.f_parity), 32'(epar));
      check_eq("beat_cnt", 32'(bus.beat_cnt), e8);
      check_eq("f_sat", 32'(bus_s.f), 32'(m_f));
      check_eq("f_parity_sat", 32'(bus_s.f_parity), 32'(epar));
      check_eq("beat_cnt_sat", 32'(bus_s.beat_cnt), e2);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic reset_checks(input string tag);
    check_eq({tag, "_out_valid"}, 32'(bus.out_valid), 32'h0);
    check_eq({tag, "_f"}, 32'(bus.f), 32'h0);
    check_eq({tag, "_f_parity"}, 32'(bus.f_parity), 32'h0);
    check_eq({tag, "_beat_cnt"}, 32'(bus.beat_cnt), 32'h0);
    check_eq({tag, "_in_ready"}, 32'(bus.in_ready), 32'h1);
    check_eq({tag, "_out_valid_sat"}, 32'(bus_s.out_valid), 32'h0);
    check_eq({tag, "_f_sat"}, 32'(bus_s.f), 32'h0);
  endtask

  // Asynchronous pulse placed between clock edges (call just after a negedge).
  task automatic pulse_reset(input string tag);
    #2 rst = 1'b0;
    #1 reset_checks(tag);
    model_reset();
    #1 rst = 1'b1;
    #0 check_eq({tag, "_in_ready_rel"}, 32'(bus.in_ready), 32'h1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    drive(0, 0, 8'h00, 8'h00, 0, 0);
    model_reset();
    #12;
    reset_checks("por");
    @(negedge clk);
    rst = 1'b1;
    #1 check_eq("por_in_ready_rel", 32'(bus.in_ready), 32'h1);

    // Mode 0 single beat.
    drive(0, 1, 8'hA5, 8'h0F, 0, 1);
    step();
    check_eq("m0_valid", 32'(bus.out_valid), 32'h1);
    check_eq("m0_f", 32'(bus.f), 32'hAA);
    check_eq("m0_par", 32'(bus.f_parity), 32'h0);
    check_eq("m0_cnt", 32'(bus.beat_cnt), 32'h1);
    drive(0, 0, 8'h00, 8'h00, 0, 1);
    step();

    // Mode 1 three-beat frame.
    drive(1, 1, 8'h01, 8'h02, 0, 1);
    step();
    check_eq("m1_b1_valid", 32'(bus.out_valid), 32'h0);
    drive(1, 1, 8'h04, 8'h08, 0, 1);
    step();
    check_eq("m1_b2_valid", 32'(bus.out_valid), 32'h0);
    drive(1, 1, 8'h10, 8'h20, 1, 1);
    step();
    check_eq("m1_valid", 32'(bus.out_valid), 32'h1);
    check_eq("m1_f", 32'(bus.f), 32'h3F);
    check_eq("m1_par", 32'(bus.f_parity), 32'h0);
    check_eq("m1_cnt", 32'(bus.beat_cnt), 32'h3);
    drive(0, 0, 8'h00, 8'h00, 0, 1);
    step();

    // Backpressure, then handoff in the same cycle.
    drive(0, 1, 8'h11, 8'h22, 0, 0);
    step();
    check_eq("bp_f1", 32'(bus.f), 32'h33);
    drive(0, 1, 8'h33, 8'h00, 0, 0);
    #1 check_eq("bp_stall_ready", 32'(bus.in_ready), 32'h0);
    step();
    check_eq("bp_hold_f", 32'(bus.f), 32'h33);
    check_eq("bp_hold_valid", 32'(bus.out_valid), 32'h1);
    drive(0, 1, 8'h33, 8'h00, 0, 1);
    #1 check_eq("bp_go_ready", 32'(bus.in_ready), 32'h1);
    step();
    check_eq("bp_f2", 32'(bus.f), 32'h33);
    check_eq("bp_cnt2", 32'(bus.beat_cnt), 32'h1);
    check_eq("bp_valid2", 32'(bus.out_valid), 32'h1);
    drive(0, 0, 8'h00, 8'h00, 0, 1);
    step();

    // Reset mid-frame discards the partial frame.
    drive(1, 1, 8'h01, 8'h02, 0, 1);
    step();
    drive(1, 1, 8'h04, 8'h08, 0, 1);
    step();
    drive(0, 0, 8'h00, 8'h00, 0, 1);
    pulse_reset("midframe");
    drive(1, 1, 8'hFF, 8'h00, 1, 1);
    step();
    check_eq("rst_f", 32'(bus.f), 32'hFF);
    check_eq("rst_par", 32'(bus.f_parity), 32'h0);
    check_eq("rst_cnt", 32'(bus.beat_cnt), 32'h1);
    drive(0, 0, 8'h00, 8'h00, 0, 1);
    step();

    // Five-beat frame: CNT_W=2 saturates at 3.
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 8'h01, 8'h00, (i == 4), 1);
      step();
    end
    check_eq("sat_cnt", 32'(bus_s.beat_cnt), 32'h3);
    check_eq("sat_f", 32'(bus_s.f), 32'h01);
    check_eq("sat_par", 32'(bus_s.f_parity), 32'h1);
    check_eq("sat_cnt_wide", 32'(bus.beat_cnt), 32'h5);
    drive(0, 0, 8'h00, 8'h00, 0, 1);
    step();

    // Mode change mid-frame is ignored.
    drive(1, 1, 8'h01, 8'h00, 0, 1);
    step();
    drive(0, 1, 8'h02, 8'h00, 0, 1);
    step();
    check_eq("mchg_no_early", 32'(bus.out_valid), 32'h0);
    drive(1, 1, 8'h04, 8'h00, 1, 1);
    step();
    check_eq("mchg_valid", 32'(bus.out_valid), 32'h1);
    check_eq("mchg_cnt", 32'(bus.beat_cnt), 32'h3);
    check_eq("mchg_f", 32'(bus.f), 32'h07);
    drive(0, 0, 8'h00, 8'h00, 0, 1);
    step();

    // Randomized traffic with occasional asynchronous reset pulses.
    for (int i = 0; i < 3000; i++) begin
      drive(bit'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom),
            ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 6));
      if ($urandom_range(0, 199) == 0) pulse_reset("rnd_rst");
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
